// File: rtl/sync_fifo_if.sv
// Handshake and status bundle for sync_fifo.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface sync_fifo_if #(
    parameter int DW = 16,
    parameter int FD = 32
);
    localparam int LW = $clog2(FD) + 1;

    logic          wrEn;
    logic [DW-1:0] wrData;
    logic          rdEn;
    logic [DW-1:0] rdData;
    logic          empty;
    logic          full;
    logic          half;
    logic          almostFull;
    logic          almostEmpty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;

    modport master (
        output wrEn, wrData, rdEn,
        input  rdData, empty, full, half, almostFull, almostEmpty, level, overflow, underflow
    );

    modport slave (
        input  wrEn, wrData, rdEn,
        output rdData, empty, full, half, almostFull, almostEmpty, level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy level, threshold flags, sticky error flags,
// synchronous flush and selectable first-word-fall-through or registered output.
module sync_fifo #(
    parameter int DW   = 16,
    parameter int FD   = 32,
    parameter int AFT  = FD - 2,
    parameter int AET  = 2,
    parameter int FWFT = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clkEn,
    input  logic       i_clr,
    sync_fifo_if.slave bus
);
    localparam int AW = $clog2(FD);
    localparam int LW = AW + 1;

    logic [DW-1:0] r_mem [FD];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [LW-1:0] r_level;
    logic          r_empty;
    logic          r_full;
    logic          r_half;
    logic          r_almostFull;
    logic          r_almostEmpty;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_rdAcc;
    logic          w_wrAcc;
    logic          w_restart;
    logic [LW-1:0] w_levelNext;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    always_comb begin
        w_rdAcc     = bus.rdEn & ~r_empty;
        w_wrAcc     = bus.wrEn & (~r_full | w_rdAcc);
        w_restart   = i_rst | (i_clkEn & i_clr);
        w_levelNext = r_level + {{AW{1'b0}}, w_wrAcc} - {{AW{1'b0}}, w_rdAcc};
    end

    always_ff @(posedge i_clk) begin
        if (w_restart) begin
            r_wp          <= '0;
            r_rp          <= '0;
            r_level       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_half        <= 1'b0;
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else if (i_clkEn) begin
            if (w_wrAcc) r_wp <= r_wp + AW'(1);
            if (w_rdAcc) r_rp <= r_rp + AW'(1);
            r_level       <= w_levelNext;
            r_empty       <= (w_levelNext == '0);
            r_full        <= (w_levelNext == LW'(FD));
            r_half        <= (w_levelNext >= LW'(FD / 2));
            r_almostFull  <= (w_levelNext >= LW'(AFT));
            r_almostEmpty <= (w_levelNext <= LW'(AET));
            r_overflow    <= r_overflow | (bus.wrEn & ~w_wrAcc);
            r_underflow   <= r_underflow | (bus.rdEn & r_empty);
        end
    end

    // Storage is deliberately not reset; only pointers define which words are live.
    always_ff @(posedge i_clk) begin
        if (!w_restart && i_clkEn && w_wrAcc) begin
            r_mem[r_wp] <= bus.wrData;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rdData = r_mem[r_rp];
        end else begin : g_regOut
            logic [DW-1:0] r_out;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_out <= '0;
                end else if (i_clkEn && !i_clr && w_rdAcc) begin
                    r_out <= r_mem[r_rp];
                end
            end

            assign bus.rdData = r_out;
        end
    endgenerate

    assign bus.level       = r_level;
    assign bus.empty       = r_empty;
    assign bus.full        = r_full;
    assign bus.half        = r_half;
    assign bus.almostFull  = r_almostFull;
    assign bus.almostEmpty = r_almostEmpty;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a FWFT and a registered-output instance share
// identical stimulus and are compared against a queue-based reference model.
module tb_sync_fifo;
    localparam int DW = 8;
    localparam int FD = 4;

    typedef struct {
        int          lvl;
        bit          ovf;
        bit          unf;
        logic [7:0]  head;
        logic [7:0]  regOut;
    } exp_t;

    logic clk;
    logic rst;
    logic clkEn;
    logic clr;

    sync_fifo_if #(.DW(DW), .FD(FD)) bus1 ();
    sync_fifo_if #(.DW(DW), .FD(FD)) bus0 ();

    sync_fifo #(.DW(DW), .FD(FD), .AFT(3), .AET(1), .FWFT(1)) dutFwft (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clkEn (clkEn),
        .i_clr   (clr),
        .bus     (bus1)
    );

    sync_fifo #(.DW(DW), .FD(FD), .AFT(3), .AET(1), .FWFT(0)) dutReg (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clkEn (clkEn),
        .i_clr   (clr),
        .bus     (bus0)
    );

    int          checks   = 0;
    int          failures = 0;
    exp_t        expQ[$];
    logic [7:0]  mq[$];
    bit          mOvf = 1'b0;
    bit          mUnf = 1'b0;
    logic [7:0]  mOut = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model at the edge, queue expectations.
    task automatic applyStimulus(input bit r, input bit en, input bit c,
                                 input bit wr, input logic [7:0] d, input bit rd);
        bit   rdAcc;
        bit   wrAcc;
        exp_t e;
        rst = r;  clkEn = en;  clr = c;
        bus1.wrEn = wr;  bus1.wrData = d;  bus1.rdEn = rd;
        bus0.wrEn = wr;  bus0.wrData = d;  bus0.rdEn = rd;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mOvf = 1'b0;  mUnf = 1'b0;  mOut = 8'h00;
        end else if (en) begin
            if (c) begin
                mq.delete();
                mOvf = 1'b0;  mUnf = 1'b0;
            end else begin
                rdAcc = rd && (mq.size() > 0);
                wrAcc = wr && ((mq.size() < FD) || rdAcc);
                if (wr && !wrAcc) mOvf = 1'b1;
                if (rd && mq.size() == 0) mUnf = 1'b1;
                if (rdAcc) mOut = mq.pop_front();
                if (wrAcc) mq.push_back(d);
            end
        end
        e.lvl    = mq.size();
        e.ovf    = mOvf;
        e.unf    = mUnf;
        e.head   = (mq.size() > 0) ? mq[0] : 8'h00;
        e.regOut = mOut;
        expQ.push_back(e);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("level",        int'(bus1.level),       e.lvl);
        cmp("empty",        int'(bus1.empty),       int'(e.lvl == 0));
        cmp("full",         int'(bus1.full),        int'(e.lvl == FD));
        cmp("half",         int'(bus1.half),        int'(e.lvl >= FD / 2));
        cmp("almostFull",   int'(bus1.almostFull),  int'(e.lvl >= 3));
        cmp("almostEmpty",  int'(bus1.almostEmpty), int'(e.lvl <= 1));
        cmp("overflow",     int'(bus1.overflow),    int'(e.ovf));
        cmp("underflow",    int'(bus1.underflow),   int'(e.unf));
        cmp("levelReg",     int'(bus0.level),       e.lvl);
        cmp("overflowReg",  int'(bus0.overflow),    int'(e.ovf));
        cmp("underflowReg", int'(bus0.underflow),   int'(e.unf));
        if (e.lvl > 0) cmp("headFwft", int'(bus1.rdData), int'(e.head));
        cmp("outReg", int'(bus0.rdData), int'(e.regOut));
    endtask

    // Monitor: consumes one expectation per cycle, mid-cycle, independent of stimulus.
    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        applyStimulus(1, 1, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);

        applyStimulus(0, 1, 0, 1, 8'h11, 0);
        applyStimulus(0, 1, 0, 1, 8'h22, 0);
        applyStimulus(0, 1, 0, 1, 8'h33, 0);
        applyStimulus(0, 1, 0, 1, 8'h44, 0);
        applyStimulus(0, 1, 0, 1, 8'h55, 0);
        applyStimulus(0, 1, 0, 1, 8'h55, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1);
        applyStimulus(0, 1, 1, 0, 8'h00, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 1, 8'($urandom), 0);
            applyStimulus(0, 1, 0, 0, 8'h00, 1);
        end

        applyStimulus(0, 1, 0, 1, 8'hA5, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 1);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);

        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 1, 8'(8'hC0 + i), 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 1);
        applyStimulus(0, 1, 1, 1, 8'hEE, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 8'hDD, 0);
        applyStimulus(0, 0, 0, 0, 8'h00, 1);
        applyStimulus(0, 1, 0, 1, 8'h77, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 1);
        applyStimulus(0, 1, 0, 1, 8'h66, 0);
        applyStimulus(1, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 1);

        for (int i = 0; i < 600; i++) begin
            int wrBias;
            wrBias = ((i / 40) % 2 == 0) ? 3 : 1;
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 3) < wrBias),
                          8'($urandom),
                          ($urandom_range(0, 3) >= wrBias));
        end

        @(negedge clk);
        #1;
        cmp("scoreboardDrained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO for intra-domain buffering, e.g. between the iteration engine and the pixel writer. It is the single-clock successor to the dual-clock gray-counter FIFO. It adds an occupancy count, a working half flag, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) or registered-read output mode, sticky overflow/underflow error flags and a synchronous flush.

Parameters:
DW, 16, data width in bits (>=1)
FD, 32, depth in words; power of two, >=4
AFT, FD-2, almost_full asserts when level >= AFT (1..FD)
AET, 2, almost_empty asserts when level <= AET (0..FD-1)
FWFT, 1, 1 = combinational head-of-queue output; 0 = registered output updated on accepted read

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
clk_en  in  1  clock enable; when 0, all state holds, including flags, level, out and errors
clr  in  1  synchronous flush (effective when clk_en=1)
wr_en  in  1  write request
in  in  DW  write data
rd_en  in  1  read request
out  out  DW  read data
empty  out  1  level == 0
full  out  1  level == FD
half  out  1  level >= FD/2
almost_full  out  1  level >= AFT
almost_empty  out  1  level <= AET
level  out  clog2(FD)+1  current word count, 0..FD
overflow  out  1  sticky: write request rejected
underflow  out  1  sticky: read request rejected

Behaviour:
- Reset values: level=0, empty=1, full=0, half=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, out=0 (FWFT=0), read and write pointers = 0.
- Reset and clr take effect on the clock edge and do not clear memory contents.
- rst takes effect regardless of clk_en.
- Storage: FD x DW register array; binary pointers wp and rp of clog2(FD) bits; each wraps FD-1 -> 0 naturally.
- rd_acc = rd_en & !empty. A read is never accepted while empty, even with a same-cycle write; no bypass.
- wr_acc = wr_en & (!full | rd_acc). When full, a write is accepted only together with an accepted read.
- On wr_acc: mem[wp] <= in; wp++. On rd_acc: rp++.
- level_next = level + wr_acc - rd_acc. Simultaneous accepts leave level unchanged.
- All status flags are registered and computed from level_next, so they are consistent with level in the same cycle.
- Flag latency: a write into an empty FIFO clears empty on the next edge. The word is readable in the following cycle.
- FWFT=1: out = mem[rp] combinationally. out is valid whenever !empty; it is undefined when empty.
- FWFT=0: out <= mem[rp] on rd_acc, so data appears one cycle after the accepted read. out holds otherwise, including through clr.
- overflow <= overflow | (wr_en & !wr_acc). underflow <= underflow | (rd_en & empty). Both are cleared only by rst or clr.
- clr has priority over wr_en and rd_en in the same cycle. Those requests are discarded and do not set the error flags. Pointers, level and flags return to their reset values; out (FWFT=0) holds.
- rst has priority over clr.
- Reset mid-operation discards all contents. No partial state survives.
- clk_en=0: wr_en and rd_en are ignored; no error flags are set.

Test Plan:
(DW=8, FD=4, AFT=3, AET=1, FWFT=1 unless stated)
- Reset then idle: empty=1, almost_empty=1, level=0, full=0, overflow=0, underflow=0.
- Write 0x11,0x22,0x33,0x44 back-to-back: level goes 1,2,3,4. half sets at level 2, almost_full at level 3, full at level 4. A 5th write (0x55) is rejected and sets overflow=1. out=0x11.
- From full, assert rd_en and wr_en=0x55 together: level stays 4 and out becomes 0x22. Then read 4 words: 0x22,0x33,0x44,0x55. Empty then sets, and a further rd_en sets underflow=1.
- Pointer wrap: 10 interleaved write/read pairs crossing index 3->0 return data in order with no loss; level never exceeds 1.
- FWFT=0: write 0xA5 then read once; out=0xA5 exactly one cycle after the rd_acc edge and holds afterwards.
- With level=3, overflow=1 and clr asserted with wr_en=1: next cycle level=0, empty=1, overflow=0, and the write is not stored. Toggling clk_en=0 with wr_en=1 for 3 cycles changes nothing.
